// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for a rate-1/2 convolutional encoder: seeds the encoder,
// serialises a byte stream MSB first, appends K-1 zero tail bits and counts returned symbols.
module conv_frame_sequencer #(
    parameter int unsigned K     = 3,
    parameter int unsigned LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_byte,
    output logic               enc_seed_load,
    output logic               enc_in_valid,
    output logic               enc_in_bit,
    input  logic               enc_out_valid,
    output logic               busy,
    output logic               done,
    output logic [LEN_W+3:0]   sym_count
);

    localparam int unsigned SYM_W = LEN_W + 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bytes_q, bytes_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_q, bit_d;
    logic [SYM_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] exp_c, cnt_inc_c;

    logic in_ready_q, in_ready_d;
    logic seed_q, seed_d;
    logic ev_q, ev_d;
    logic eb_q, eb_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bytes_d = bytes_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;

        exp_c     = SYM_W'({len_q, 3'b000}) + SYM_W'(K - 1);
        cnt_inc_c = cnt_q + SYM_W'(enc_out_valid);

        if (state_q != S_IDLE) begin
            cnt_d = cnt_inc_c;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SEED;
                    len_d   = frame_len;
                    bytes_d = frame_len;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SEED: begin
                bit_d   = '0;
                state_d = (len_q != '0) ? S_LOAD : S_TAIL;
            end
            S_LOAD: begin
                if (in_valid) begin
                    shreg_d = in_byte;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    bytes_d = bytes_q - LEN_W'(1);
                    bit_d   = '0;
                    state_d = (bytes_q != LEN_W'(1)) ? S_LOAD : S_TAIL;
                end
            end
            S_TAIL: begin
                if (bit_q == 3'(K - 2)) begin
                    state_d = S_DRAIN;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            // The symbol arriving this cycle counts toward completion
            S_DRAIN: begin
                if (cnt_inc_c == exp_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        in_ready_d = (state_d == S_LOAD);
        seed_d     = (state_d == S_SEED);
        ev_d       = (state_d == S_SHIFT) || (state_d == S_TAIL);
        eb_d       = (state_d == S_SHIFT) && shreg_d[7];
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            bytes_q    <= '0;
            shreg_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            seed_q     <= 1'b0;
            ev_q       <= 1'b0;
            eb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bytes_q    <= bytes_d;
            shreg_q    <= shreg_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            seed_q     <= seed_d;
            ev_q       <= ev_d;
            eb_q       <= eb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign enc_seed_load = seed_q;
    assign enc_in_valid  = ev_q;
    assign enc_in_bit    = eb_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sym_count     = cnt_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: a per-frame timeline model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_conv_frame_sequencer;

    localparam int K     = 3;
    localparam int LEN_W = 8;
    localparam int MAXC  = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort, in_valid, in_ready;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       in_byte;
    logic             enc_seed_load, enc_in_valid, enc_in_bit, enc_out_valid;
    logic             busy, done;
    logic [LEN_W+3:0] sym_count;

    conv_frame_sequencer #(.K(K), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frame_len(frame_len), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .enc_seed_load(enc_seed_load),
        .enc_in_valid(enc_in_valid), .enc_in_bit(enc_in_bit),
        .enc_out_valid(enc_out_valid), .busy(busy), .done(done),
        .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    // Encoder stand-in: one symbol per input bit, one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) enc_out_valid <= 1'b0;
        else        enc_out_valid <= enc_in_valid;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Expected per-cycle timeline of one frame
    bit          e_busy [MAXC];
    bit          e_rdy  [MAXC];
    bit          e_seed [MAXC];
    bit          e_ev   [MAXC];
    bit          e_eb   [MAXC];
    bit          e_done [MAXC];
    int          e_cnt  [MAXC];
    bit          st_valid [MAXC];
    logic [7:0]  st_byte  [MAXC];
    logic [7:0]  fb [3];
    int          fs [3];
    int          n_cyc;
    int          prev_cnt = 0;

    int          cyc;
    bit          chk_en = 1'b0;
    logic [15:0] obs_bits;
    int          obs_nbits, obs_done_cyc, obs_done_n, obs_rdy_n;

    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == 0) begin
                obs_bits = '0; obs_nbits = 0; obs_done_cyc = -1; obs_done_n = 0; obs_rdy_n = 0;
            end
            chk($sformatf("busy@%0d", cyc), busy, e_busy[cyc]);
            chk($sformatf("in_ready@%0d", cyc), in_ready, e_rdy[cyc]);
            chk($sformatf("seed@%0d", cyc), enc_seed_load, e_seed[cyc]);
            chk($sformatf("enc_in_valid@%0d", cyc), enc_in_valid, e_ev[cyc]);
            chk($sformatf("enc_in_bit@%0d", cyc), enc_in_bit, e_eb[cyc]);
            chk($sformatf("done@%0d", cyc), done, e_done[cyc]);
            chk($sformatf("sym_count@%0d", cyc), sym_count, e_cnt[cyc]);
            if (enc_in_valid) begin
                obs_bits = {obs_bits[14:0], enc_in_bit};
                obs_nbits++;
            end
            if (done) begin
                obs_done_n++;
                obs_done_cyc = cyc;
            end
            if (in_ready) obs_rdy_n++;
        end
    end

    // Build the timeline from frame parameters: cycle 0 carries start, cycle 1 is the seed
    task automatic build(input int len, input int abort_at, input bit v_in_shift);
        int t, lc, done_c, last_busy, n;
        logic [7:0] bt;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_rdy[c] = 0; e_seed[c] = 0; e_ev[c] = 0;
            e_eb[c] = 0; e_done[c] = 0; st_valid[c] = 0; st_byte[c] = 8'h00;
        end
        e_seed[1] = 1;
        t = 2;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < fs[i]; j++) e_rdy[t + j] = 1;
            lc = t + fs[i];
            e_rdy[lc] = 1;
            st_valid[lc] = 1;
            st_byte[lc] = fb[i];
            bt = fb[i];
            for (int j = 0; j < 8; j++) begin
                e_ev[lc + 1 + j] = 1;
                e_eb[lc + 1 + j] = bt[7 - j];
                if (v_in_shift) begin
                    st_valid[lc + 1 + j] = 1;
                    st_byte[lc + 1 + j] = 8'hC3;
                end
            end
            t = lc + 9;
        end
        for (int j = 0; j < K - 1; j++) e_ev[t + j] = 1;
        done_c = t + K;
        e_done[done_c] = 1;
        for (int c = 1; c <= done_c; c++) e_busy[c] = 1;
        last_busy = done_c;
        if (abort_at > 0) begin
            for (int c = abort_at + 1; c < MAXC; c++) begin
                e_busy[c] = 0; e_rdy[c] = 0; e_seed[c] = 0;
                e_ev[c] = 0; e_eb[c] = 0; e_done[c] = 0;
            end
            last_busy = abort_at;
        end
        n_cyc = last_busy + 3;
        // A symbol is counted in the cycle it arrives if the block is still busy
        for (int c = 0; c < MAXC; c++) begin
            if (c == 0) e_cnt[c] = prev_cnt;
            else begin
                n = 0;
                for (int b = 0; b < MAXC - 1; b++)
                    if (e_ev[b] && (b + 1 <= c - 1) && (b + 1 <= last_busy)) n++;
                e_cnt[c] = n;
            end
        end
    endtask

    task automatic run_frame(input int len, input int abort_at, input int start_at,
                             input bit v_in_shift, input int rst_at);
        build(len, abort_at, v_in_shift);
        frame_len = LEN_W'(len);
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk); #1;
            cyc      = c;
            start    = (c == 0) || (c == start_at);
            abort    = (c == abort_at);
            in_valid = st_valid[c];
            in_byte  = st_byte[c];
            chk_en   = 1'b1;
            if (c == rst_at) begin
                chk_en = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_seed", enc_seed_load, 0);
                chk("rst_enc_in_valid", enc_in_valid, 0);
                chk("rst_enc_in_bit", enc_in_bit, 0);
                chk("rst_done", done, 0);
                chk("rst_sym_count", sym_count, 0);
                break;
            end
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        start = 0; abort = 0; in_valid = 0; in_byte = 8'h00;
        prev_cnt = e_cnt[n_cyc - 1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_byte = 8'h00; frame_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_enc_in_valid", enc_in_valid, 0);
        chk("reset_sym_count", sym_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1-byte frame, 0xA5
        fb[0] = 8'hA5; fs[0] = 0;
        run_frame(1, -1, -1, 0, -1);
        chk("a5_bits", obs_bits[9:0], 10'h294);
        chk("a5_nbits", obs_nbits, 10);
        chk("a5_done_cycle", obs_done_cyc, 14);
        chk("a5_sym_count", sym_count, 10);

        // Tail-only frame
        run_frame(0, -1, -1, 0, -1);
        chk("tail_sym_count", sym_count, 2);
        chk("tail_in_ready_cycles", obs_rdy_n, 0);
        chk("tail_done_cycle", obs_done_cyc, 5);

        // Back-pressure: second byte withheld for 5 cycles
        fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56;
        fs[0] = 0; fs[1] = 5; fs[2] = 0;
        run_frame(3, -1, -1, 0, -1);
        chk("bp_sym_count", sym_count, 26);
        chk("bp_done_count", obs_done_n, 1);
        chk("bp_done_cycle", obs_done_cyc, 37);

        // Abort on the 4th SHIFT cycle of byte 1 (cycle 6)
        fb[0] = 8'hF0; fb[1] = 8'h0F; fs[0] = 0; fs[1] = 0;
        run_frame(2, 6, -1, 0, -1);
        chk("abort_sym_count", sym_count, 3);
        chk("abort_done_count", obs_done_n, 0);
        chk("abort_busy", busy, 0);

        // Clean frame after abort, with stray start and in_valid during SHIFT
        fb[0] = 8'h3C; fs[0] = 0;
        run_frame(1, -1, 5, 1, -1);
        chk("clean_bits", obs_bits[9:0], 10'h0F0);
        chk("clean_done_cycle", obs_done_cyc, 14);
        chk("clean_sym_count", sym_count, 10);

        // start together with abort in IDLE
        @(posedge clk); #1 start = 1; abort = 1; frame_len = LEN_W'(1);
        @(posedge clk); #1 start = 0; abort = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("sa_busy%0d", i), busy, 0);
            chk($sformatf("sa_seed%0d", i), enc_seed_load, 0);
            chk($sformatf("sa_sym_count%0d", i), sym_count, prev_cnt);
        end

        // Reset pulsed during TAIL (cycle 11), then a fresh frame
        fb[0] = 8'hA5; fs[0] = 0;
        run_frame(1, -1, -1, 0, 11);
        @(posedge clk); #1 rst_n = 1'b1;
        prev_cnt = 0;
        run_frame(1, -1, -1, 0, -1);
        chk("post_rst_done_cycle", obs_done_cyc, 14);
        chk("post_rst_sym_count", sym_count, 10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
